// File: rtl/seg_display_pkg.sv
// Shared constants and hex-to-segment decode for the debug display.
package seg_display_pkg;

  localparam int unsigned SEG_W = 7;

  // All segments dark, expressed active-high; output polarity is applied later.
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [SEG_W-1:0] hex2seg(input logic [3:0] nib);
    logic [SEG_W-1:0] seg;
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_debug_display_if.sv
// Source-select inputs and segment-bank outputs of the debug display.
interface seg_debug_display_if
  import seg_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned NUM_SRC    = 8,
  parameter int unsigned SEL_W      = $clog2(NUM_SRC)
);

  logic [SEL_W-1:0]        sel;
  logic [32*NUM_SRC-1:0]   src_data;
  logic                    freeze;
  logic [SEG_W-1:0]        led;
  logic [NUM_DIGITS-1:0]   en;
  logic                    frame_tick;

  modport master (output sel, src_data, freeze, input led, en, frame_tick);
  modport slave  (input sel, src_data, freeze, output led, en, frame_tick);

endinterface

// File: rtl/seg_scan_timer.sv
// Refresh divider and digit scan index; wrap_c marks the edge that returns to digit 0.
module seg_scan_timer #(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 100000,
  localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int unsigned CNT_W      = $clog2(REFRESH_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] idx,
  output logic             wrap_c
);

  logic [CNT_W-1:0] cnt;
  logic             last_c;
  logic             idx_last_c;

  assign last_c     = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign idx_last_c = (idx == IDX_W'(NUM_DIGITS - 1));
  assign wrap_c     = last_c && idx_last_c;

  // Count cycles per digit and step the digit index on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= last_c ? '0 : cnt + CNT_W'(1);
      if (last_c) begin
        idx <= idx_last_c ? '0 : idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/seg_debug_display.sv
// Multi-source debug word display: selects a source, snapshots it once per
// scan frame and time-multiplexes its hex digits onto the segment bank.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_debug_display
  import seg_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned SEL_W       = $clog2(NUM_SRC),
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  seg_debug_display_if.slave  bus
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam logic [SEG_W-1:0]      LED_INV = {SEG_W{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] EN_INV  = {NUM_DIGITS{ACTIVE_LOW}};

  logic [IDX_W-1:0] idx;
  logic             wrap_c;
  logic             wrap_q;
  logic [31:0]      sel_word_c;
  logic [VAL_W-1:0] snap;
  logic             show_c;

  seg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .idx    (idx),
    .wrap_c (wrap_c)
  );

  // Source mux; selector codes with no source behind them read as zero.
  always_comb begin
    sel_word_c = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (bus.sel == SEL_W'(k)) sel_word_c = bus.src_data[32*k +: 32];
    end
  end

  // Frame snapshot, taken only at scan wrap so a frame never shows two values.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap <= '0;
    end else if (wrap_c && !bus.freeze) begin
      snap <= sel_word_c[VAL_W-1:0];
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] top_c;

  // Highest non-zero digit of the snapshot; digit 0 is always shown.
  always_comb begin
    top_c = '0;
    for (int unsigned d = 1; d < NUM_DIGITS; d++) begin
      if (snap[4*d +: 4] != 4'h0) top_c = IDX_W'(d);
    end
  end

  assign show_c = (idx <= top_c);
`else
  assign show_c = 1'b1;
`endif

  // Registered segment/enable drive plus frame pulse aligned with digit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q         <= 1'b0;
      bus.frame_tick <= 1'b0;
      bus.led        <= SEG_OFF ^ LED_INV;
      bus.en         <= EN_INV;
    end else begin
      wrap_q         <= wrap_c;
      bus.frame_tick <= wrap_q;
      bus.led        <= (show_c ? hex2seg(snap[4*idx +: 4]) : SEG_OFF) ^ LED_INV;
      bus.en         <= (show_c ? (NUM_DIGITS'(1) << idx) : '0) ^ EN_INV;
    end
  end

endmodule

// File: tb/tb_seg_debug_display.sv
// Scoreboard bench for seg_debug_display: 8 digits, 6 sources, 4-cycle refresh, active-low.
module tb_seg_debug_display;

  localparam int unsigned ND = 8;
  localparam int unsigned NS = 6;
  localparam int unsigned SW = $clog2(NS);
  localparam int unsigned RD = 4;
  localparam int unsigned FR = ND * RD;

  typedef struct packed {
    logic [ND-1:0] en;
    logic [6:0]    led;
    logic          tick;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  seg_debug_display_if #(.NUM_DIGITS(ND), .NUM_SRC(NS), .SEL_W(SW)) bus ();

  seg_debug_display #(
    .NUM_DIGITS  (ND),
    .NUM_SRC     (NS),
    .SEL_W       (SW),
    .REFRESH_DIV (RD),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  task automatic set_src(input int k, input logic [31:0] v);
    bus.src_data[32*k +: 32] = v;
  endtask

  // Expected per-cycle output for the first n cycles of a frame showing val.
  task automatic push_frame(input logic [31:0] val, input logic tick0, input int n);
    int top;
    top = ND - 1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    top = 0;
    for (int d = 1; d < ND; d++) if (val[4*d +: 4] != 4'h0) top = d;
`endif
    for (int c = 0; c < n; c++) begin
      int   d;
      exp_t e;
      d = c / RD;
      if (d <= top) begin
        e.en  = ~(ND'(1) << d);
        e.led = ~seg_of(val[4*d +: 4]);
      end else begin
        e.en  = '1;
        e.led = 7'h7F;
      end
      e.tick = tick0 && (c == 0);
      q.push_back(e);
    end
  endtask

  task automatic push_reset();
    exp_t e;
    e.en = '1; e.led = 7'h7F; e.tick = 1'b0;
    q.push_back(e);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) push_reset();
    push_frame(32'h0, 1'b0, FR);
    for (int i = 0; i < 3 + FR; i++) begin
      exp_t e;
      @(negedge clk);
      n_tests++;
      if (q.size() == 0) begin
        n_fail++; $display("FAIL reset c%0d: scoreboard empty", i);
      end else begin
        e = q.pop_front();
        if ({bus.en, bus.led, bus.frame_tick} !== e) begin
          n_fail++;
          $display("FAIL reset c%0d: got en=%h led=%h tick=%b, want en=%h led=%h tick=%b",
                   i, bus.en, bus.led, bus.frame_tick, e.en, e.led, e.tick);
        end
      end
      if (i == 2) rst = 1'b0;
    end
  endtask

  task automatic test_capture();
    push_frame(32'h1234ABCF, 1'b1, FR);
    for (int i = 0; i < FR; i++) begin
      exp_t e;
      @(negedge clk);
      n_tests++;
      if (q.size() == 0) begin
        n_fail++; $display("FAIL capture c%0d: scoreboard empty", i);
      end else begin
        e = q.pop_front();
        if ({bus.en, bus.led, bus.frame_tick} !== e) begin
          n_fail++;
          $display("FAIL capture c%0d: got en=%h led=%h tick=%b, want en=%h led=%h tick=%b",
                   i, bus.en, bus.led, bus.frame_tick, e.en, e.led, e.tick);
        end
      end
    end
  endtask

  task automatic test_sel_change();
    set_src(3, 32'h0);
    push_frame(32'h1234ABCF, 1'b1, FR);
    push_frame(32'h0, 1'b1, FR);
    for (int i = 0; i < 2 * FR; i++) begin
      exp_t e;
      @(negedge clk);
      n_tests++;
      if (q.size() == 0) begin
        n_fail++; $display("FAIL sel_change c%0d: scoreboard empty", i);
      end else begin
        e = q.pop_front();
        if ({bus.en, bus.led, bus.frame_tick} !== e) begin
          n_fail++;
          $display("FAIL sel_change c%0d: got en=%h led=%h tick=%b, want en=%h led=%h tick=%b",
                   i, bus.en, bus.led, bus.frame_tick, e.en, e.led, e.tick);
        end
      end
      if (i == 11) bus.sel = SW'(3);
    end
  endtask

  task automatic test_freeze();
    bus.sel = SW'(2);
    push_frame(32'h0, 1'b1, FR);
    for (int f = 0; f < 5; f++) push_frame(32'h1234ABCF, 1'b1, FR);
    for (int i = 0; i < 6 * FR; i++) begin
      exp_t e;
      @(negedge clk);
      n_tests++;
      if (q.size() == 0) begin
        n_fail++; $display("FAIL freeze c%0d: scoreboard empty", i);
      end else begin
        e = q.pop_front();
        if ({bus.en, bus.led, bus.frame_tick} !== e) begin
          n_fail++;
          $display("FAIL freeze c%0d: got en=%h led=%h tick=%b, want en=%h led=%h tick=%b",
                   i, bus.en, bus.led, bus.frame_tick, e.en, e.led, e.tick);
        end
      end
      if (i == 41) begin
        bus.freeze = 1'b1;
        set_src(2, 32'hFFFFFFFF);
      end
      if (i == 169) bus.freeze = 1'b0;
    end
  endtask

  task automatic test_bad_sel();
    push_frame(32'hFFFFFFFF, 1'b1, FR);
    push_frame(32'h0, 1'b1, FR);
    for (int i = 0; i < 2 * FR; i++) begin
      exp_t e;
      @(negedge clk);
      n_tests++;
      if (q.size() == 0) begin
        n_fail++; $display("FAIL bad_sel c%0d: scoreboard empty", i);
      end else begin
        e = q.pop_front();
        if ({bus.en, bus.led, bus.frame_tick} !== e) begin
          n_fail++;
          $display("FAIL bad_sel c%0d: got en=%h led=%h tick=%b, want en=%h led=%h tick=%b",
                   i, bus.en, bus.led, bus.frame_tick, e.en, e.led, e.tick);
        end
      end
      if (i == 9) bus.sel = SW'(7);
    end
  endtask

  task automatic test_blank();
    push_frame(32'h0, 1'b1, FR);
    push_frame(32'h000000A5, 1'b1, FR);
    for (int i = 0; i < 2 * FR; i++) begin
      exp_t e;
      @(negedge clk);
      n_tests++;
      if (q.size() == 0) begin
        n_fail++; $display("FAIL blank c%0d: scoreboard empty", i);
      end else begin
        e = q.pop_front();
        if ({bus.en, bus.led, bus.frame_tick} !== e) begin
          n_fail++;
          $display("FAIL blank c%0d: got en=%h led=%h tick=%b, want en=%h led=%h tick=%b",
                   i, bus.en, bus.led, bus.frame_tick, e.en, e.led, e.tick);
        end
      end
      if (i == 4) begin
        set_src(0, 32'h000000A5);
        bus.sel = SW'(0);
      end
    end
  endtask

  task automatic test_reset_mid();
    push_frame(32'h000000A5, 1'b1, 22);
    push_reset();
    push_frame(32'h0, 1'b0, FR);
    push_frame(32'h000000A5, 1'b1, FR);
    for (int i = 0; i < 23 + 2 * FR; i++) begin
      exp_t e;
      @(negedge clk);
      n_tests++;
      if (q.size() == 0) begin
        n_fail++; $display("FAIL reset_mid c%0d: scoreboard empty", i);
      end else begin
        e = q.pop_front();
        if ({bus.en, bus.led, bus.frame_tick} !== e) begin
          n_fail++;
          $display("FAIL reset_mid c%0d: got en=%h led=%h tick=%b, want en=%h led=%h tick=%b",
                   i, bus.en, bus.led, bus.frame_tick, e.en, e.led, e.tick);
        end
      end
      if (i == 21) rst = 1'b1;
      if (i == 22) rst = 1'b0;
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.sel      = SW'(2);
    bus.freeze   = 1'b0;
    bus.src_data = '0;
    set_src(2, 32'h1234ABCF);
    test_reset();
    test_capture();
    test_sel_change();
    test_freeze();
    test_bad_sel();
    test_blank();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
